// File: rtl/parking_time_controller_pkg.sv
// -----------------------------------------------------------------------------
// parking_time_controller_pkg
// Shared constants, types and the FSM state encoding for the parking-time
// controller slice. Imported by the interface, the top and its sub-modules.
// -----------------------------------------------------------------------------
package parking_time_controller_pkg;

  localparam int NUM_SLOTS = 8;   // power of two, 2..16
  localparam int SLOT_W    = 3;   // log2(NUM_SLOTS)
  localparam int TIME_W    = 8;   // fixed by the shared 8-bit subtractor

  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [TIME_W-1:0]    time_t;
  typedef logic [NUM_SLOTS-1:0] occ_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lot is full when every occupancy bit is set.
  function automatic logic all_occupied(input occ_t occ);
    return &occ;
  endfunction

endpackage

// File: rtl/parking_time_controller_if.sv
// -----------------------------------------------------------------------------
// parking_time_controller_if
// Bundles the gate/keypad request handshakes, the duration valid/ready
// handshake and the status outputs of the parking-time controller.
//   master : gate sensors / keypad / billing side (drives requests, dur_ready)
//   slave  : parking_time_controller (drives acks, duration and status)
// -----------------------------------------------------------------------------
interface parking_time_controller_if;
  import parking_time_controller_pkg::*;

  logic  tick;        // time-base advance strobe
  logic  ent_req;     // entry request, level until ent_ack
  logic  ent_ack;     // one-cycle entry grant
  slot_t ent_slot;    // allocated slot, valid with ent_ack
  logic  full;        // all slots occupied
  logic  ext_req;     // exit request, level until ext_ack
  slot_t ext_slot;    // slot being vacated
  logic  ext_ack;     // one-cycle exit acceptance
  logic  ext_err;     // with ext_ack: slot was not occupied
  logic  dur_valid;   // duration available
  time_t dur;         // parking duration
  logic  dur_ready;   // consumer accepts dur
  occ_t  occupancy;   // bit i = slot i occupied
  time_t cur_time;    // current time base

  modport master (
    output tick, ent_req, ext_req, ext_slot, dur_ready,
    input  ent_ack, ent_slot, full, ext_ack, ext_err, dur_valid, dur,
           occupancy, cur_time
  );

  modport slave (
    input  tick, ent_req, ext_req, ext_slot, dur_ready,
    output ent_ack, ent_slot, full, ext_ack, ext_err, dur_valid, dur,
           occupancy, cur_time
  );

endinterface

// File: rtl/parking_time_controller_free_slot_finder.sv
// -----------------------------------------------------------------------------
// free_slot_finder
// Combinational lowest-zero priority encoder over the occupancy map.
//   occupancy_i : bit i = slot i occupied
//   slot_o      : lowest-index free slot (0 when none free)
//   any_free_o  : at least one slot is free
// -----------------------------------------------------------------------------
module free_slot_finder #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic [NUM_SLOTS-1:0] occupancy_i,
  output logic [SLOT_W-1:0]    slot_o,
  output logic                 any_free_o
);

  // Scan from the top down so the last hit, and therefore the winner, is the
  // lowest free index.
  always_comb begin
    slot_o     = '0;
    any_free_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        slot_o     = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_time_controller_ripple_sub.sv
// -----------------------------------------------------------------------------
// ripple_sub
// Shared W-bit ripple-borrow subtractor: diff_o = a_i - b_i (mod 2^W),
// built as a_i + ~b_i + 1 through a chain of full adders.
//   a_i    : minuend (exit time)
//   b_i    : subtrahend (entry time)
//   diff_o : difference
// -----------------------------------------------------------------------------
module ripple_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b1;  // the +1 of the two's complement

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic b_n;
    assign b_n        = ~b_i[gi];
    assign diff_o[gi] = a_i[gi] ^ b_n ^ carry[gi];
    // The carry out of the top bit is the no-borrow flag, not needed here.
    if (gi < W - 1) begin : g_carry
      assign carry[gi+1] = (a_i[gi] & b_n) | (carry[gi] & (a_i[gi] ^ b_n));
    end
  end

endmodule

// File: rtl/parking_time_controller.sv
// -----------------------------------------------------------------------------
// parking_time_controller
// Keeps a free-running time base, per-slot entry timestamps and an occupancy
// map; arbitrates car-entry against car-exit requests and schedules the shared
// subtractor to produce the parking duration (exit - entry, mod 256), which is
// returned over a valid/ready handshake.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of parking_time_controller_if (requests, acks,
//           duration handshake, occupancy, full, cur_time)
// -----------------------------------------------------------------------------
module parking_time_controller
  import parking_time_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  parking_time_controller_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  time_t  cur_time_q, cur_time_d;
  occ_t   occ_q, occ_d;
  time_t  ts_q [NUM_SLOTS];
  logic   rr_pri_q, rr_pri_d;        // 0: exit wins a contest, 1: entry wins
  logic   ent_ack_q, ent_ack_d;
  slot_t  ent_slot_q, ent_slot_d;
  logic   ext_ack_q, ext_ack_d;
  logic   ext_err_q, ext_err_d;
  slot_t  exit_slot_q, exit_slot_d;
  time_t  exit_time_q, exit_time_d;
  time_t  dur_q, dur_d;

  logic   ts_wr_en;
  logic   dur_valid;

  // ---------------------------------------------------------------------------
  // Helpers: free-slot search and the shared subtractor
  // ---------------------------------------------------------------------------
  slot_t free_slot;
  logic  any_free;
  time_t sub_diff;

  free_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_free_slot_finder (
    .occupancy_i (occ_q),
    .slot_o      (free_slot),
    .any_free_o  (any_free)
  );

  ripple_sub #(
    .W (TIME_W)
  ) u_ripple_sub (
    .a_i    (exit_time_q),
    .b_i    (ts_q[exit_slot_q]),
    .diff_o (sub_diff)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // A request is still high in the cycle its ack is shown (the requester only
  // drops it after seeing the ack), so it is masked for that cycle to avoid a
  // second grant for the same car.
  // ---------------------------------------------------------------------------
  logic ent_elig, ext_elig, contested, grant_ent, grant_ext;

  assign ent_elig  = bus.ent_req & any_free & ~ent_ack_q;
  assign ext_elig  = bus.ext_req & ~ext_ack_q;
  assign contested = ent_elig & ext_elig;
  assign grant_ext = ext_elig & (~ent_elig | ~rr_pri_q);
  assign grant_ent = ent_elig & ~grant_ext;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_pri_d    = rr_pri_q;
    ent_ack_d   = 1'b0;
    ent_slot_d  = ent_slot_q;
    ext_ack_d   = 1'b0;
    ext_err_d   = 1'b0;
    exit_slot_d = exit_slot_q;
    exit_time_d = exit_time_q;
    dur_d       = dur_q;
    occ_d       = occ_q;
    ts_wr_en    = 1'b0;
    // The time base runs in every state; grants in this cycle snapshot
    // cur_time_q, i.e. the pre-increment value.
    cur_time_d  = bus.tick ? cur_time_q + TIME_W'(1) : cur_time_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ext) begin
          ext_ack_d = 1'b1;
          if (occ_q[bus.ext_slot]) begin
            exit_slot_d           = bus.ext_slot;
            exit_time_d           = cur_time_q;
            occ_d[bus.ext_slot]   = 1'b0;
            state_d               = ST_CALC;
          end else begin
            ext_err_d = 1'b1;
          end
        end else if (grant_ent) begin
          ent_ack_d        = 1'b1;
          ent_slot_d       = free_slot;
          occ_d[free_slot] = 1'b1;
          ts_wr_en         = 1'b1;
        end
        if (contested) begin
          rr_pri_d = ~rr_pri_q;
        end
      end
      ST_CALC: begin
        dur_d   = sub_diff;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.dur_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dur_valid = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_time_q  <= '0;
      occ_q       <= '0;
      rr_pri_q    <= 1'b0;
      ent_ack_q   <= 1'b0;
      ent_slot_q  <= '0;
      ext_ack_q   <= 1'b0;
      ext_err_q   <= 1'b0;
      exit_slot_q <= '0;
      exit_time_q <= '0;
      dur_q       <= '0;
    end else begin
      cur_time_q  <= cur_time_d;
      occ_q       <= occ_d;
      rr_pri_q    <= rr_pri_d;
      ent_ack_q   <= ent_ack_d;
      ent_slot_q  <= ent_slot_d;
      ext_ack_q   <= ext_ack_d;
      ext_err_q   <= ext_err_d;
      exit_slot_q <= exit_slot_d;
      exit_time_q <= exit_time_d;
      dur_q       <= dur_d;
    end
  end

  // Per-slot entry timestamps; only the slot picked by the finder is written.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_ts
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ts_q[gi] <= '0;
      end else if (ts_wr_en && (free_slot == SLOT_W'(gi))) begin
        ts_q[gi] <= cur_time_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign bus.ent_ack   = ent_ack_q;
  assign bus.ent_slot  = ent_slot_q;
  assign bus.full      = all_occupied(occ_q);
  assign bus.ext_ack   = ext_ack_q;
  assign bus.ext_err   = ext_err_q;
  assign bus.dur_valid = dur_valid;
  assign bus.dur       = dur_q;
  assign bus.occupancy = occ_q;
  assign bus.cur_time  = cur_time_q;

endmodule
